// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared state encoding and default widths for the stall controller
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int CNT_W_DEF        = 16;
    localparam int MAX_STALL_DEF    = 3;
    localparam int DRAIN_CYCLES_DEF = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline write-enable / bubble / flush control with halt drain
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MAX_STALL    = MAX_STALL_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             HazardStall,
    input  logic             BranchTaken,
    input  logic             Jump,
    input  logic             HaltReq,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Halted,
    output logic             StallError,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // One counter serves as the stall-run length in RUN and the drain progress in DRAIN.
    localparam int RW = max_int($clog2(MAX_STALL + 1) + 1, $clog2(DRAIN_CYCLES + 1));
    localparam logic [RW-1:0] STALL_LIM  = RW'(MAX_STALL - 1);
    localparam logic [RW-1:0] DRAIN_LAST = RW'(DRAIN_CYCLES - 1);

    state_t        state;
    logic [RW-1:0] run_cnt;
    logic          stall_inc;
    logic          flush_inc;
    logic          run_inc;
    logic          drain_done;

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        case (state)
            RUN: begin
                // Stale operands during a stall make any branch decision meaningless.
                if (HazardStall) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end else if (BranchTaken || Jump) begin
                    IF_ID_Flush  = 1'b1;
                end
            end
            default: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end
        endcase
    end

    assign stall_inc  = (state == RUN) && HazardStall;
    assign flush_inc  = (state == RUN) && !HazardStall && (BranchTaken || Jump);
    assign run_inc    = stall_inc || ((state == DRAIN) && HaltReq);
    assign drain_done = (state == DRAIN) && HaltReq && (run_cnt == DRAIN_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= RUN;
            Halted     <= 1'b0;
            StallError <= 1'b0;
        end else begin
            if (stall_inc && (run_cnt >= STALL_LIM)) begin
                StallError <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (HaltReq && !HazardStall) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!HaltReq) begin
                        state <= RUN;
                    end else if (drain_done) begin
                        state  <= HALTED;
                        Halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!HaltReq) begin
                        state  <= RUN;
                        Halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    Halted <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (1'b0),
        .inc   (stall_inc),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (1'b0),
        .inc   (flush_inc),
        .count (FlushCount)
    );

    sat_counter #(.W(RW)) u_run_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (!run_inc),
        .inc   (run_inc),
        .count (run_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl with directed vectors
module tb_pipeline_stall_ctrl;

    localparam int CW = 4;

    logic          Clk;
    logic          Rst_n;
    logic          HazardStall;
    logic          BranchTaken;
    logic          Jump;
    logic          HaltReq;
    logic          PCWrite;
    logic          IF_ID_Write;
    logic          IF_ID_Flush;
    logic          ID_EX_Bubble;
    logic          Halted;
    logic          StallError;
    logic [CW-1:0] StallCount;
    logic [CW-1:0] FlushCount;

    typedef struct {
        logic [5:0] ctl;
        int         sc;
        int         fc;
        int         id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    pipeline_stall_ctrl #(
        .MAX_STALL    (3),
        .CNT_W        (CW),
        .DRAIN_CYCLES (4)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .HazardStall  (HazardStall),
        .BranchTaken  (BranchTaken),
        .Jump         (Jump),
        .HaltReq      (HaltReq),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Bubble (ID_EX_Bubble),
        .Halted       (Halted),
        .StallError   (StallError),
        .StallCount   (StallCount),
        .FlushCount   (FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Halted, StallError}
    task automatic push_exp(input logic [5:0] ctl, input int sc, input int fc);
        exp_t e;
        e.ctl = ctl;
        e.sc  = sc;
        e.fc  = fc;
        e.id  = vec_id;
        vec_id++;
        q.push_back(e);
    endtask

    task automatic vec(input logic hs, input logic bt, input logic jp, input logic hr,
                       input logic [5:0] ctl, input int sc, input int fc);
        @(posedge Clk);
        #1;
        HazardStall = hs;
        BranchTaken = bt;
        Jump        = jp;
        HaltReq     = hr;
        push_exp(ctl, sc, fc);
    endtask

    // Reset pulse lies entirely between two rising edges; the check happens while it is low.
    task automatic async_reset();
        @(posedge Clk);
        #2;
        Rst_n       = 1'b0;
        HazardStall = 1'b0;
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        HaltReq     = 1'b0;
        push_exp(6'b110000, 0, 0);
        #5;
        Rst_n = 1'b1;
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [5:0] got;
            e   = q.pop_front();
            got = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Halted, StallError};
            checks++;
            if ((got !== e.ctl) || (StallCount !== CW'(e.sc)) || (FlushCount !== CW'(e.fc))) begin
                errors++;
                $display("FAIL vec%0d got ctl=%b sc=%0d fc=%0d expected ctl=%b sc=%0d fc=%0d",
                         e.id, got, StallCount, FlushCount, e.ctl, e.sc, e.fc);
            end
        end
    end

    initial begin
        Rst_n       = 1'b0;
        HazardStall = 1'b0;
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        HaltReq     = 1'b0;
        push_exp(6'b110000, 0, 0);
        #12;
        Rst_n = 1'b1;

        // idle after reset
        vec(0, 0, 0, 0, 6'b110000, 0, 0);
        vec(0, 0, 0, 0, 6'b110000, 0, 0);
        // load-use stall, two cycles
        vec(1, 0, 0, 0, 6'b000100, 0, 0);
        vec(1, 0, 0, 0, 6'b000100, 1, 0);
        vec(0, 0, 0, 0, 6'b110000, 2, 0);
        // stall beats branch, then branch+jump together counts once
        vec(1, 1, 0, 0, 6'b000100, 2, 0);
        vec(0, 1, 1, 0, 6'b111000, 3, 0);
        vec(0, 0, 0, 0, 6'b110000, 3, 1);
        // runaway stall: error set at the third edge, sticky afterwards
        vec(1, 0, 0, 0, 6'b000100, 3, 1);
        vec(1, 0, 0, 0, 6'b000100, 4, 1);
        vec(1, 0, 0, 0, 6'b000100, 5, 1);
        vec(1, 0, 0, 0, 6'b000101, 6, 1);
        vec(1, 0, 0, 0, 6'b000101, 7, 1);
        vec(0, 0, 0, 0, 6'b110001, 8, 1);
        // halt: four drain cycles (hazard/branch ignored), halted, then resume
        vec(0, 0, 0, 1, 6'b110001, 8, 1);
        vec(0, 0, 0, 1, 6'b000101, 8, 1);
        vec(1, 1, 1, 1, 6'b000101, 8, 1);
        vec(0, 0, 0, 1, 6'b000101, 8, 1);
        vec(0, 0, 0, 1, 6'b000101, 8, 1);
        vec(0, 0, 0, 1, 6'b000111, 8, 1);
        vec(0, 0, 0, 0, 6'b000111, 8, 1);
        vec(0, 0, 0, 0, 6'b110001, 8, 1);
        // halt with a jump in the entry cycle, abandoned after two drain cycles
        vec(0, 0, 1, 1, 6'b111001, 8, 1);
        vec(0, 0, 0, 1, 6'b000101, 8, 2);
        vec(0, 0, 0, 1, 6'b000101, 8, 2);
        vec(0, 0, 0, 0, 6'b000101, 8, 2);
        vec(0, 0, 0, 0, 6'b110001, 8, 2);
        // halt request held off by a stall
        vec(1, 0, 0, 1, 6'b000101, 8, 2);
        vec(0, 0, 0, 1, 6'b110001, 9, 2);
        vec(0, 0, 0, 0, 6'b000101, 9, 2);
        vec(0, 0, 0, 0, 6'b110001, 9, 2);
        // twenty flushes saturate the 4-bit flush counter
        for (int i = 0; i < 20; i++) begin
            vec(0, i[0], 1, 0, 6'b111001, 9, ((2 + i) > 15) ? 15 : (2 + i));
        end
        vec(0, 0, 0, 0, 6'b110001, 9, 15);
        // reset mid-drain
        vec(0, 0, 0, 1, 6'b110001, 9, 15);
        vec(0, 0, 0, 1, 6'b000101, 9, 15);
        async_reset();
        vec(0, 0, 0, 0, 6'b110000, 0, 0);
        // reset mid-stall
        vec(1, 0, 0, 0, 6'b000100, 0, 0);
        vec(1, 0, 0, 0, 6'b000100, 1, 0);
        async_reset();
        vec(0, 0, 0, 0, 6'b110000, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge Clk);
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue pending=%0d required=0", q.size());
        end
        @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
